// File: rtl/dma_bench_pkg.sv
// Shared definitions for the DMA benchmark generator and receiver:
// FSM encoding, TUSER field offsets, magic code, LFSR polynomial and beat size.
package dma_bench_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2,
    ST_GAP  = 2'd3
  } gen_state_e;

  localparam int TUSER_LEN_LSB = 0;
  localparam int TUSER_SRC_LSB = 16;
  localparam int TUSER_DST_LSB = 24;

  localparam logic [23:0] MAGIC_CODE_DEFAULT = 24'haecafe;
  localparam int          BEAT_BYTES         = 32;

  // x^32+x^22+x^2+x+1 in right-shift Galois form
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  typedef struct packed {
    gen_state_e  state;
    logic        stop_pending;
    logic [15:0] beat_idx;
    logic [15:0] gap_cnt;
  } gen_dbg_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

  function automatic logic [15:0] clamp_len(input logic [15:0] len,
                                            input logic [15:0] lo,
                                            input logic [15:0] hi);
    if (len < lo) return lo;
    if (len > hi) return hi;
    return len;
  endfunction

endpackage

// File: rtl/dma_gen_payload.sv
// Payload source for one 256-bit beat: counter pattern by default, or a
// 32-bit Galois LFSR (8 words per beat) when DMA_TRAFFIC_GEN_PRBS_EN is defined.
module dma_gen_payload
  import dma_bench_pkg::*;
(
  input  logic         ACLK,
  input  logic         RESETN,
  input  logic         seed,
  input  logic         advance,
  input  logic [15:0]  seq,
  input  logic [7:0]   beat_idx,
  output logic [255:0] payload
);

`ifdef DMA_TRAFFIC_GEN_PRBS_EN
  logic [31:0]       lfsr_q;
  logic [8:0][31:0]  chain;
  logic              unused_inputs;

  // Word w of a beat is the LFSR state w steps after the beat's base state.
  always_comb begin
    chain    = '0;
    chain[0] = seed ? LFSR_SEED : lfsr_q;
    for (int w = 0; w < 8; w++) begin
      chain[w+1] = lfsr_step(chain[w]);
    end
  end

  always_comb begin
    payload = '0;
    for (int w = 0; w < 8; w++) begin
      payload[32*w +: 32] = chain[w];
    end
  end

  always_ff @(posedge ACLK) begin
    if (!RESETN) begin
      lfsr_q <= LFSR_SEED;
    end else if (advance) begin
      lfsr_q <= chain[8];
    end
  end

  assign unused_inputs = ^{seq, beat_idx};
`else
  logic unused_inputs;

  always_comb begin
    payload = '0;
    for (int w = 0; w < 8; w++) begin
      payload[32*w +: 32] = {seq, beat_idx, 8'(w)};
    end
  end

  assign unused_inputs = ^{ACLK, RESETN, seed, advance};
`endif

endmodule

// File: rtl/dma_traffic_gen.sv
// AXI4-Stream benchmark packet generator with registered stream outputs.
// Optional PRBS payload selected by DMA_TRAFFIC_GEN_PRBS_EN.
module dma_traffic_gen
  import dma_bench_pkg::*;
#(
  parameter int          C_M_AXIS_DATA_WIDTH  = 256,
  parameter int          C_M_AXIS_TUSER_WIDTH = 128,
  parameter logic [23:0] USER_MAGIC_CODE      = MAGIC_CODE_DEFAULT,
  parameter logic [15:0] MAX_PKT_LEN          = 16'd9600,
  parameter logic [15:0] MIN_PKT_LEN          = 16'd64
) (
  input  logic                              ACLK,
  input  logic                              RESETN,
  input  logic                              cfg_start,
  input  logic                              cfg_stop,
  input  logic [15:0]                       cfg_pkt_len,
  input  logic [31:0]                       cfg_num_pkts,
  input  logic [15:0]                       cfg_gap,
  input  logic [7:0]                        cfg_src_port,
  input  logic [7:0]                        cfg_dst_port,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic                              busy,
  output logic [31:0]                       pkts_sent,
  output logic [31:0]                       bytes_sent
);

  localparam int STRB_W = C_M_AXIS_DATA_WIDTH / 8;

  // Handshake: a beat moves when TVALID && TREADY; while TVALID is high the
  // beat registers are frozen, and TVALID only falls after a transfer or reset.

  gen_state_e  state_q, state_d;
  logic [15:0] len_q, beats_q, gap_q, beat_q, gap_cnt_q;
  logic [31:0] num_q, seq_q, pkts_q, bytes_q;
  logic [7:0]  src_q, dst_q;
  logic        stop_pending_q;

  logic        fire, start_now, load, pkt_done, stop_any, run_end;
  logic [15:0] nxt_idx, cfg_len_c, cfg_beats_c;
  logic [15:0] cur_len, cur_beats;
  logic [7:0]  cur_src, cur_dst;
  logic [31:0] nxt_seq;
  logic [4:0]  len_rem;
  logic        beat_last;
  logic [255:0]                     payload;
  logic [C_M_AXIS_DATA_WIDTH-1:0]   beat_tdata;
  logic [STRB_W-1:0]                beat_strb;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]  beat_tuser;
  gen_dbg_t                         dbg_probe_unused;

  assign fire        = M_AXIS_TVALID && M_AXIS_TREADY;
  assign stop_any    = stop_pending_q | cfg_stop;
  assign run_end     = ((num_q != 32'd0) && (pkts_q + 32'd1 == num_q)) || stop_any;
  assign cfg_len_c   = clamp_len(cfg_pkt_len, MIN_PKT_LEN, MAX_PKT_LEN);
  assign cfg_beats_c = 16'((cfg_len_c + 16'd31) >> 5);
  assign nxt_seq     = pkt_done ? seq_q + 32'd1 : seq_q;

  // The first beat is built on the same edge the config is latched.
  assign cur_len   = start_now ? cfg_len_c    : len_q;
  assign cur_beats = start_now ? cfg_beats_c  : beats_q;
  assign cur_src   = start_now ? cfg_src_port : src_q;
  assign cur_dst   = start_now ? cfg_dst_port : dst_q;

  always_ff @(posedge ACLK) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    start_now = 1'b0;
    load      = 1'b0;
    pkt_done  = 1'b0;
    nxt_idx   = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d   = ST_HEAD;
          start_now = 1'b1;
          load      = 1'b1;
          nxt_idx   = 16'd0;
        end
      end
      ST_HEAD, ST_BODY: begin
        if (fire) begin
          if (M_AXIS_TLAST) begin
            pkt_done = 1'b1;
            if (run_end) begin
              state_d = ST_IDLE;
            end else if (gap_q == 16'd0) begin
              state_d = ST_HEAD;
              load    = 1'b1;
              nxt_idx = 16'd0;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            state_d = ST_BODY;
            load    = 1'b1;
            nxt_idx = beat_q + 16'd1;
          end
        end
      end
      ST_GAP: begin
        if (stop_any) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q == gap_q - 16'd1) begin
          state_d = ST_HEAD;
          load    = 1'b1;
          nxt_idx = 16'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  dma_gen_payload u_payload (
    .ACLK     (ACLK),
    .RESETN   (RESETN),
    .seed     (start_now),
    .advance  (load),
    .seq      (nxt_seq[15:0]),
    .beat_idx (nxt_idx[7:0]),
    .payload  (payload)
  );

  // Next-beat builder; only captured into the output registers when load is set.
  assign len_rem   = cur_len[4:0];
  assign beat_last = (nxt_idx == cur_beats - 16'd1);

  always_comb begin
    beat_tdata = payload;
    if (nxt_idx == 16'd0) begin
      beat_tdata[63:0] = {nxt_seq, 8'h00, USER_MAGIC_CODE};
    end
    beat_strb = '1;
    if (beat_last && (len_rem != 5'd0)) begin
      beat_strb = ~({STRB_W{1'b1}} << len_rem);
    end
    beat_tuser = '0;
    beat_tuser[TUSER_LEN_LSB +: 16] = cur_len;
    beat_tuser[TUSER_SRC_LSB +: 8]  = cur_src;
    beat_tuser[TUSER_DST_LSB +: 8]  = cur_dst;
  end

  always_ff @(posedge ACLK) begin
    if (!RESETN) begin
      len_q          <= '0;
      beats_q        <= '0;
      num_q          <= '0;
      gap_q          <= '0;
      src_q          <= '0;
      dst_q          <= '0;
      seq_q          <= '0;
      beat_q         <= '0;
      gap_cnt_q      <= '0;
      stop_pending_q <= 1'b0;
      pkts_q         <= '0;
      bytes_q        <= '0;
      M_AXIS_TDATA   <= '0;
      M_AXIS_TSTRB   <= '0;
      M_AXIS_TUSER   <= '0;
      M_AXIS_TVALID  <= 1'b0;
      M_AXIS_TLAST   <= 1'b0;
    end else begin
      if (start_now) begin
        len_q   <= cfg_len_c;
        beats_q <= cfg_beats_c;
        num_q   <= cfg_num_pkts;
        gap_q   <= cfg_gap;
        src_q   <= cfg_src_port;
        dst_q   <= cfg_dst_port;
        pkts_q  <= '0;
        bytes_q <= '0;
      end
      if (pkt_done) begin
        pkts_q  <= pkts_q + 32'd1;
        bytes_q <= bytes_q + {16'd0, len_q};
        seq_q   <= seq_q + 32'd1;
      end
      if (load) begin
        beat_q        <= nxt_idx;
        M_AXIS_TDATA  <= beat_tdata;
        M_AXIS_TSTRB  <= beat_strb;
        M_AXIS_TUSER  <= beat_tuser;
        M_AXIS_TLAST  <= beat_last;
        M_AXIS_TVALID <= 1'b1;
      end else if (fire) begin
        M_AXIS_TVALID <= 1'b0;
      end
      gap_cnt_q      <= (state_q == ST_GAP && state_d == ST_GAP) ? gap_cnt_q + 16'd1 : 16'd0;
      stop_pending_q <= (state_d == ST_IDLE) ? 1'b0 : (stop_pending_q | cfg_stop);
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign pkts_sent  = pkts_q;
  assign bytes_sent = bytes_q;

  // Probe point for bound checkers.
  assign dbg_probe_unused = '{state: state_q, stop_pending: stop_pending_q,
                              beat_idx: beat_q, gap_cnt: gap_cnt_q};

endmodule

// File: tb/tb_dma_traffic_gen.sv
// Bench for dma_traffic_gen: random stimulus against a packet-level reference
// model and a scoreboard; also handles DMA_TRAFFIC_GEN_PRBS_EN builds.
module tb_dma_traffic_gen;

  localparam int BW = 417;  // {tlast, tstrb[31:0], tuser[127:0], tdata[255:0]}

  logic         ACLK = 1'b0;
  logic         RESETN;
  logic         cfg_start, cfg_stop;
  logic [15:0]  cfg_pkt_len, cfg_gap;
  logic [31:0]  cfg_num_pkts;
  logic [7:0]   cfg_src_port, cfg_dst_port;
  logic [255:0] M_AXIS_TDATA;
  logic [31:0]  M_AXIS_TSTRB;
  logic [127:0] M_AXIS_TUSER;
  logic         M_AXIS_TVALID, M_AXIS_TLAST;
  logic         M_AXIS_TREADY;
  logic         busy;
  logic [31:0]  pkts_sent, bytes_sent;

  always #5 ACLK = ~ACLK;

  dma_traffic_gen dut (
    .ACLK          (ACLK),
    .RESETN        (RESETN),
    .cfg_start     (cfg_start),
    .cfg_stop      (cfg_stop),
    .cfg_pkt_len   (cfg_pkt_len),
    .cfg_num_pkts  (cfg_num_pkts),
    .cfg_gap       (cfg_gap),
    .cfg_src_port  (cfg_src_port),
    .cfg_dst_port  (cfg_dst_port),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TSTRB  (M_AXIS_TSTRB),
    .M_AXIS_TUSER  (M_AXIS_TUSER),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .busy          (busy),
    .pkts_sent     (pkts_sent),
    .bytes_sent    (bytes_sent)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW-1:0] exp_q[$];
  logic [63:0]   head_q[$];
  logic [31:0]   model_seq  = 32'd0;
  logic [31:0]   model_lfsr = 32'd1;
  logic [127:0]  first_tuser;
  logic [31:0]   last_tstrb;
  logic [BW-1:0] held_beat;
  logic          held_v   = 1'b0;
  logic          in_gap   = 1'b0;
  logic          pkt_first = 1'b1;
  logic          rand_ready = 1'b0;
  int            gap_seen = 0;
  int            exp_gap  = 0;
  int            tot_beats = 0;
  int            run_beats = 0;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp_len(input int l);
    if (l < 64) return 64;
    if (l > 9600) return 9600;
    return l;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  // Reference model: expand one packet into its expected beats.
  task automatic model_packet(input logic [15:0] len_raw, input logic [7:0] src, input logic [7:0] dst);
    int len, beats, valid;
    logic [15:0]  len_v;
    logic [255:0] d;
    logic [31:0]  strb;
    logic [127:0] tuser;
    logic [7:0]   kk, ww;
    logic         tl;
    len   = clamp_len(int'(len_raw));
    beats = (len + 31) / 32;
    len_v = 16'(len);
    tuser = {96'd0, dst, src, len_v};
    for (int k = 0; k < beats; k++) begin
      kk = 8'(k);
      for (int w = 0; w < 8; w++) begin
        ww = 8'(w);
`ifdef DMA_TRAFFIC_GEN_PRBS_EN
        d[32*w +: 32] = model_lfsr;
        model_lfsr    = lfsr_next(model_lfsr);
`else
        d[32*w +: 32] = {model_seq[15:0], kk, ww};
`endif
      end
      if (k == 0) d[63:0] = {model_seq, 8'h00, 24'haecafe};
      valid = len - 32 * k;
      for (int b = 0; b < 32; b++) strb[b] = (b < valid);
      tl = (k == beats - 1);
      exp_q.push_back({tl, strb, tuser, d});
    end
    model_seq = model_seq + 32'd1;
  endtask

  always @(posedge ACLK) begin
    #1;
    M_AXIS_TREADY = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge ACLK) begin
    logic [BW-1:0] obs;
    obs = {M_AXIS_TLAST, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TDATA};
    if (!RESETN) begin
      held_v = 1'b0;
      in_gap = 1'b0;
    end else begin
      if (held_v) check_eq("stall_hold", {M_AXIS_TVALID, obs}, {1'b1, held_beat});
      if (in_gap && M_AXIS_TVALID) begin
        check_eq("gap_len", gap_seen, exp_gap);
        in_gap = 1'b0;
      end else if (in_gap) begin
        gap_seen++;
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        tot_beats++;
        run_beats++;
        if (pkt_first) begin
          head_q.push_back(M_AXIS_TDATA[63:0]);
          first_tuser = M_AXIS_TUSER;
        end
        if (exp_q.size() == 0) check_eq("extra_beat", 1, 0);
        else check_eq("beat", obs, exp_q.pop_front());
        pkt_first = M_AXIS_TLAST;
        if (M_AXIS_TLAST) begin
          last_tstrb = M_AXIS_TSTRB;
          in_gap     = 1'b1;
          gap_seen   = 0;
        end
      end
      held_v    = M_AXIS_TVALID && !M_AXIS_TREADY;
      held_beat = obs;
    end
  end

  task automatic start_run(input logic [15:0] len, input logic [31:0] num, input logic [15:0] gap,
                           input logic [7:0] src, input logic [7:0] dst, input logic stop, input int n_exp);
    model_lfsr = 32'd1;
    for (int i = 0; i < n_exp; i++) model_packet(len, src, dst);
    exp_gap   = int'(gap);
    in_gap    = 1'b0;
    pkt_first = 1'b1;
    run_beats = 0;
    head_q.delete();
    cfg_pkt_len  = len;
    cfg_num_pkts = num;
    cfg_gap      = gap;
    cfg_src_port = src;
    cfg_dst_port = dst;
    cfg_start    = 1'b1;
    cfg_stop     = stop;
    @(posedge ACLK); #1;
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge ACLK); #1;
      n++;
    end
    check_eq("run_done_busy", busy, 0);
  endtask

  task automatic end_checks(input int pkts, input int bytes);
    check_eq("pkts_sent", pkts_sent, pkts);
    check_eq("bytes_sent", bytes_sent, bytes);
    check_eq("exp_q_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tvalid"}, M_AXIS_TVALID, 0);
    check_eq({tag, "_tdata"}, M_AXIS_TDATA, 0);
    check_eq({tag, "_tuser"}, M_AXIS_TUSER, 0);
    check_eq({tag, "_tstrb_tlast"}, {M_AXIS_TSTRB, M_AXIS_TLAST}, 0);
    check_eq({tag, "_busy_cnt"}, {busy, pkts_sent, bytes_sent}, 0);
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int base, n, num, len, gap;
    RESETN = 1'b0;
    cfg_start = 1'b0; cfg_stop = 1'b0;
    cfg_pkt_len = '0; cfg_num_pkts = '0; cfg_gap = '0;
    cfg_src_port = '0; cfg_dst_port = '0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs("rst");
    @(posedge ACLK); #1;
    RESETN = 1'b1;
    @(posedge ACLK); #1;

    // Two 64-byte packets, back to back
    start_run(16'd64, 32'd2, 16'd0, 8'h02, 8'h01, 1'b0, 2);
    wait_idle(200);
    end_checks(2, 128);
    check_eq("t1_beats", run_beats, 4);
    check_eq("t1_magic", head_q[0][23:0], 24'haecafe);
    check_eq("t1_seq0", head_q[0][63:32], 0);
    check_eq("t1_seq1", head_q[1][63:32], 1);
    check_eq("t1_tuser", first_tuser[31:0], 32'h0102_0040);

    // Partial last beat and low clamp
    start_run(16'd70, 32'd1, 16'd0, 8'h11, 8'h22, 1'b0, 1);
    wait_idle(200);
    end_checks(1, 70);
    check_eq("t2_beats", run_beats, 3);
    check_eq("t2_last_strb", last_tstrb, 32'h0000_003F);
    start_run(16'd20, 32'd1, 16'd0, 8'h33, 8'h44, 1'b0, 1);
    wait_idle(200);
    end_checks(1, 64);
    check_eq("t2_clamp_beats", run_beats, 2);
    check_eq("t2_clamp_len", first_tuser[15:0], 16'h0040);

    // Random back-pressure, random configurations, high clamp
    rand_ready = 1'b1;
    start_run(16'd96, 32'd3, 16'd2, 8'h05, 8'h06, 1'b0, 3);
    wait_idle(2000);
    end_checks(3, 288);
    check_eq("t3_beats", run_beats, 9);
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 400);
      num = $urandom_range(1, 3);
      gap = $urandom_range(0, 3);
      start_run(16'(len), 32'(num), 16'(gap), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 1'b0, num);
      wait_idle(3000);
      end_checks(num, num * clamp_len(len));
    end
    start_run(16'hFFFF, 32'd1, 16'd0, 8'h7E, 8'h7F, 1'b0, 1);
    wait_idle(5000);
    end_checks(1, 9600);
    check_eq("t3_max_beats", run_beats, 300);

    // Endless run with gaps, ignored restart, stop during packet 3
    rand_ready = 1'b0;
    base = tot_beats;
    start_run(16'd96, 32'd0, 16'd5, 8'h09, 8'h0A, 1'b0, 3);
    cfg_pkt_len = 16'd500;
    cfg_start   = 1'b1;
    @(posedge ACLK); #1;
    cfg_start = 1'b0;
    n = 0;
    while ((tot_beats - base) < 7 && n < 500) begin
      @(posedge ACLK); #1;
      n++;
    end
    check_eq("t4_reach_pkt3", (tot_beats - base) >= 7, 1);
    cfg_stop = 1'b1;
    @(posedge ACLK); #1;
    cfg_stop = 1'b0;
    wait_idle(500);
    end_checks(3, 288);

    // Start and stop together: exactly one packet
    start_run(16'd64, 32'd0, 16'd0, 8'h01, 8'h02, 1'b1, 1);
    wait_idle(200);
    end_checks(1, 64);

    // Reset in the middle of a packet, then restart from seq 0
    start_run(16'd200, 32'd1, 16'd0, 8'h0C, 8'h0D, 1'b0, 1);
    n = 0;
    while (run_beats < 2 && n < 200) begin
      @(posedge ACLK); #1;
      n++;
    end
    RESETN = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    check_reset_outputs("t5_rst");
    exp_q.delete();
    model_seq = 32'd0;
    @(posedge ACLK); #1;
    RESETN = 1'b1;
    @(posedge ACLK); #1;
    start_run(16'd64, 32'd1, 16'd0, 8'h0E, 8'h0F, 1'b0, 1);
    wait_idle(200);
    end_checks(1, 64);
    check_eq("t5_seq_restart", head_q[0][63:32], 0);

    // Payload under stalls (PRBS in that build)
    rand_ready = 1'b1;
    start_run(16'd64, 32'd1, 16'd0, 8'h10, 8'h20, 1'b0, 1);
    wait_idle(500);
    end_checks(1, 64);
    rand_ready = 1'b0;

    repeat (4) @(posedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_traffic_gen.md
Name: dma_traffic_gen

Overview:
- AXI4-Stream packet generator; the transmit-side counterpart of the DMA benchmark receiver/counter.
- Emits configurable bursts of user packets: magic code in beat 0, sequence number, and length/port fields in TUSER. The benchmark monitor and DMA path can then be exercised at line rate without host traffic.
- Sits between a register/control block and the DMA or output-port AXIS slave.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, stream data width in bits; only 256 is supported.
- C_M_AXIS_TUSER_WIDTH, 128, TUSER width.
- USER_MAGIC_CODE, 24'haecafe, value placed in beat-0 TDATA[23:0].
- MAX_PKT_LEN, 16'd9600, upper clamp on packet length in bytes.
- MIN_PKT_LEN, 16'd64, lower clamp on packet length in bytes.

Ports:
- ACLK  in  1  clock
- RESETN  in  1  reset (see Behaviour)
- cfg_start  in  1  one-cycle pulse: latch config and begin a run
- cfg_stop  in  1  one-cycle pulse: finish the current packet, then go idle
- cfg_pkt_len  in  16  packet length in bytes
- cfg_num_pkts  in  32  packets per run; 0 = run until stopped
- cfg_gap  in  16  idle cycles inserted after each packet's TLAST beat
- cfg_src_port  in  8  TUSER[23:16] value
- cfg_dst_port  in  8  TUSER[31:24] value
- M_AXIS_TDATA  out  256  stream data
- M_AXIS_TSTRB  out  32  byte strobes
- M_AXIS_TUSER  out  128  sideband
- M_AXIS_TVALID  out  1  valid
- M_AXIS_TLAST  out  1  last beat
- M_AXIS_TREADY  in  1  downstream ready
- busy  out  1  run in progress
- pkts_sent  out  32  packets completed in the current run
- bytes_sent  out  32  bytes completed in the current run; wraps modulo 2^32

Behaviour:
- Reset: RESETN is synchronous and active-low; clock is ACLK.
  - During reset all outputs are 0, state is IDLE, the sequence counter is 0 and the latched config is 0.
  - Reset asserted mid-packet drops TVALID on the next edge. There is no TLAST completion.
- All stream outputs are registered.
- Handshake:
  - A beat transfers when TVALID && TREADY.
  - Once TVALID is high, TDATA/TSTRB/TUSER/TLAST hold stable until the transfer.
  - TVALID never drops without a transfer, except on reset.
- Length latch: cfg_start in IDLE latches all cfg_* inputs.
  - len = clamp(cfg_pkt_len, MIN_PKT_LEN, MAX_PKT_LEN).
  - beats = ceil(len/32).
  - cfg_start while busy is ignored.
- FSM states: IDLE, HEAD, BODY, GAP.
  - IDLE -> HEAD on cfg_start. busy rises on the same edge; pkts_sent and bytes_sent clear.
  - HEAD: beat 0.
    - TDATA[23:0]=USER_MAGIC_CODE, [31:24]=0, [63:32]=seq, [255:64]=payload.
    - On transfer: if beats==1, the packet completes; otherwise -> BODY.
  - BODY: beats 1..beats-1. TDATA = payload for beat index k. TLAST on beat beats-1. On the TLAST transfer the packet completes.
  - Packet complete:
    - pkts_sent+1, bytes_sent+len, seq+1 (wraps at 2^32).
    - If the run is done (cfg_num_pkts!=0 and pkts_sent+1==cfg_num_pkts) or a stop is pending -> IDLE, busy falls.
    - Else if gap==0 -> HEAD (back-to-back, no bubble).
    - Else -> GAP.
  - GAP: counts gap cycles with TVALID=0, then -> HEAD.
    - A stop pending in GAP -> IDLE immediately.
- TUSER, constant within a packet: [15:0]=len, [23:16]=src, [31:24]=dst, [127:32]=0.
- TSTRB: all ones except the last beat. On the last beat the low (len mod 32) bytes are set; if len mod 32 == 0, all 32 bytes are set.
- Payload default: each 32-bit word w of beat k = {seq[15:0], k[7:0], w[7:0]}.
- cfg_stop:
  - In IDLE it is ignored.
  - Otherwise it sets stop_pending, which clears on entering IDLE.
  - cfg_start and cfg_stop in the same cycle in IDLE: start wins, then stop_pending=1, so exactly one packet is sent.
- Back-pressure: TREADY low for any duration stalls the generator without loss or duplication.

Optional Feature:
- Macro: DMA_TRAFFIC_GEN_PRBS_EN.
- Defined: payload words (HEAD [255:64], all BODY words) come from a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1.
  - Seeded with 32'h1 at cfg_start.
  - Advances 8 steps per transferred beat; no advance while stalled.
  - Magic code and seq fields are unchanged.
- Undefined: counter payload as above; no LFSR logic is synthesized.

Decomposition:
- Shared package dma_bench_pkg:
  - FSM state encoding.
  - TUSER field offsets (LEN, SRC, DST).
  - Magic-code default.
  - LFSR polynomial constant.
  - Beat-bytes constant (32).
  - This package is also usable by the receiver.
- One sub-module, dma_gen_payload: takes seq, beat index and an advance strobe; returns the 256-bit payload (counter or PRBS). All FSM and handshake logic stays in the top.

Test Plan:
1. TREADY=1, len=64, num=2, gap=0, src=8'h02, dst=8'h01.
   - Expect 4 beats, back-to-back.
   - Beat 0 TDATA[23:0]=24'haecafe, [63:32]=0 then 1.
   - TUSER[31:0]=32'h0102_0040.
   - pkts_sent=2, bytes_sent=128; busy falls after the last TLAST.
2. len=70, num=1.
   - Expect 3 beats; last TSTRB=32'h0000003F.
   - len=20 clamps to 64: 2 beats, TUSER[15:0]=16'h0040.
3. TREADY random 50% duty.
   - Scoreboard checks held TDATA/TUSER stable while stalled.
   - Beat count 3 for len=96; no lost or duplicated beats.
4. num=0, gap=5, cfg_stop asserted mid-beat 1 of packet 3.
   - Packet 3 completes with TLAST, then IDLE; pkts_sent=3.
   - Exactly 5 TVALID=0 cycles between packets.
5. RESETN low during BODY.
   - Next cycle TVALID=0 and all outputs 0.
   - After release, cfg_start restarts with seq=0.
6. With DMA_TRAFFIC_GEN_PRBS_EN, len=64, num=1.
   - Payload matches the reference LFSR model from seed 1.
   - Stall cycles do not change the sequence.
